// File: rtl/arb_client4_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : arb_client4_pkg
//  Purpose  : Shared definitions for the arb_client4 requester block:
//             client FSM state encoding, client-to-grant-bit mapping and
//             the grant legality (one-hot-or-zero) helper.
//  Revision : 1.0 - initial release
// ============================================================================
package arb_client4_pkg;

    localparam int NUM_CLIENTS = 4;

    // Client N maps to vector bit (4 - N): client1 is the MSB.
    localparam int C1 = 3;
    localparam int C2 = 2;
    localparam int C3 = 1;
    localparam int C4 = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_USE  = 2'd2
    } slot_state_t;

    // True when at most one bit of the grant vector is set.
    function automatic logic onehot0(input logic [NUM_CLIENTS-1:0] v);
        return (v & (v - {{(NUM_CLIENTS-1){1'b0}}, 1'b1})) == '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arb_client_slot.sv
`default_nettype none
// ============================================================================
//  Module   : arb_client_slot
//  Purpose  : One requester client: pending-job counter, IDLE/REQ/USE FSM,
//             minimum-wait qualification of grants and timed USE phase.
//  Ports    : clk, rst        - clock, asynchronous active-high reset
//             i_job           - one-cycle job pulse
//             i_grant         - this client's grant bit
//             i_grant_ok      - grant vector currently legal and no error
//             o_request       - registered request to the arbiter
//             o_busy          - client is in USE
//             o_done          - pulse on the last USE cycle
//             o_drop          - pulse when a job is lost at PEND_MAX
//             o_timeout       - sticky REQ watchdog flag (ARB_CLIENT4_WDOG_EN)
//  Options  : ARB_CLIENT4_WDOG_EN adds the REQ watchdog.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_client_slot
    import arb_client4_pkg::*;
#(
    parameter int PEND_MAX   = 7,
    parameter int HOLD       = 5,
    parameter int MIN_WAIT   = 4
`ifdef ARB_CLIENT4_WDOG_EN
    ,
    parameter int WDOG_LIMIT = 64
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_job,
    input  logic i_grant,
    input  logic i_grant_ok,
    output logic o_request,
    output logic o_busy,
    output logic o_done,
    output logic o_drop
`ifdef ARB_CLIENT4_WDOG_EN
    ,
    output logic o_timeout
`endif
);

    localparam int PW = $clog2(PEND_MAX + 1);
    localparam int WW = (MIN_WAIT < 1) ? 1 : $clog2(MIN_WAIT + 1);

    localparam logic [PW-1:0] C_PEND_MAX = PW'(PEND_MAX);
    localparam logic [WW-1:0] C_MIN_WAIT = WW'(MIN_WAIT);
    localparam logic [7:0]    C_HOLD_M1  = 8'(HOLD - 1);

    slot_state_t   r_state;
    slot_state_t   w_state_next;
    logic [PW-1:0] r_pend;
    logic [PW-1:0] w_pend_next;
    logic [WW-1:0] r_wait;
    logic [WW-1:0] w_wait_next;
    logic [7:0]    r_hold;
    logic [7:0]    w_hold_next;
    logic          r_request;

    logic w_accept;
    logic w_drop;
    logic w_store;

    assign w_accept = (r_state == ST_REQ) && i_grant && i_grant_ok &&
                      (r_wait >= C_MIN_WAIT);

    // A job at the ceiling is only kept if a slot frees up the same cycle.
    assign w_drop  = i_job && (r_pend == C_PEND_MAX) && !w_accept;
    assign w_store = i_job && !w_drop;

    always_comb begin
        w_pend_next = r_pend;
        case ({w_store, w_accept})
            2'b10:   w_pend_next = r_pend + 1'b1;
            2'b01:   w_pend_next = r_pend - 1'b1;
            default: w_pend_next = r_pend;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_hold_next  = r_hold;
        case (r_state)
            ST_IDLE: begin
                if (w_pend_next != '0) begin
                    w_state_next = ST_REQ;
                    w_wait_next  = '0;
                end
            end
            ST_REQ: begin
                if (w_accept) begin
                    w_state_next = ST_USE;
                    w_hold_next  = C_HOLD_M1;
                end else if (r_wait < C_MIN_WAIT) begin
                    w_wait_next = r_wait + 1'b1;
                end
            end
            ST_USE: begin
                if (r_hold == 8'd0) begin
                    if (w_pend_next != '0) begin
                        w_state_next = ST_REQ;
                        w_wait_next  = '0;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_hold_next = r_hold - 8'd1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pend    <= '0;
            r_wait    <= '0;
            r_hold    <= 8'd0;
            r_request <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pend    <= w_pend_next;
            r_wait    <= w_wait_next;
            r_hold    <= w_hold_next;
            // Request follows the state we are entering, so it drops on the
            // accept edge and the arbiter always sees a falling edge.
            r_request <= (w_state_next == ST_REQ);
        end
    end

    assign o_request = r_request;
    assign o_busy    = (r_state == ST_USE);
    assign o_done    = (r_state == ST_USE) && (r_hold == 8'd0);
    assign o_drop    = w_drop;

`ifdef ARB_CLIENT4_WDOG_EN
    localparam int WDW = $clog2(WDOG_LIMIT + 1);
    localparam logic [WDW-1:0] C_WDOG_LIMIT = WDW'(WDOG_LIMIT);

    logic [WDW-1:0] r_wdog;
    logic [WDW-1:0] w_wdog_inc;
    logic           r_timeout;

    assign w_wdog_inc = r_wdog + 1'b1;

    // r_wdog holds the number of REQ cycles already completed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog    <= '0;
            r_timeout <= 1'b0;
        end else if (r_state == ST_REQ) begin
            if (r_wdog != C_WDOG_LIMIT) begin
                r_wdog <= w_wdog_inc;
            end
            if (w_wdog_inc == C_WDOG_LIMIT) begin
                r_timeout <= 1'b1;
            end
        end else begin
            r_wdog <= '0;
        end
    end

    assign o_timeout = r_timeout;
`endif

endmodule
`default_nettype wire

// File: rtl/arb_client4.sv
`default_nettype none
// ============================================================================
//  Module   : arb_client4
//  Purpose  : Requester-side companion to the 4-way queued arbiter. Queues
//             jobs for four clients, drives request1..request4, consumes the
//             one-hot grant vector, times the USE phase and flags illegal
//             grant vectors.
//  Ports    : clock, reset      - clock, asynchronous active-high reset
//             job_i[3:0]        - job pulses (bit3 = client1 .. bit0 = client4)
//             grant_i[3:0]      - arbiter grant vector, same mapping
//             request1..4       - registered requests to the arbiter
//             busy_o[3:0]       - client in USE
//             done_o[3:0]       - last-USE-cycle pulse
//             drop_o[3:0]       - job lost at PEND_MAX
//             err_o             - sticky illegal-grant flag
//             timeout_o[3:0]    - sticky REQ watchdog (ARB_CLIENT4_WDOG_EN)
//  Options  : ARB_CLIENT4_WDOG_EN adds timeout_o and the WDOG_LIMIT parameter.
//  Revision : 1.0 - initial release
// ============================================================================
module arb_client4
    import arb_client4_pkg::*;
#(
    parameter int PEND_MAX   = 7,
    parameter int HOLD       = 5,
    parameter int MIN_WAIT   = 4
`ifdef ARB_CLIENT4_WDOG_EN
    ,
    parameter int WDOG_LIMIT = 64
`endif
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] job_i,
    input  logic [NUM_CLIENTS-1:0] grant_i,
    output logic                   request1,
    output logic                   request2,
    output logic                   request3,
    output logic                   request4,
    output logic [NUM_CLIENTS-1:0] busy_o,
    output logic [NUM_CLIENTS-1:0] done_o,
    output logic [NUM_CLIENTS-1:0] drop_o,
    output logic                   err_o
`ifdef ARB_CLIENT4_WDOG_EN
    ,
    output logic [NUM_CLIENTS-1:0] timeout_o
`endif
);

    logic                   w_grant_legal;
    logic                   w_grant_ok;
    logic                   r_err;
    logic [NUM_CLIENTS-1:0] w_request;

    assign w_grant_legal = onehot0(grant_i);

    // Once an illegal vector has been seen no further grant is trusted, and
    // the illegal vector itself must not let any client in during its cycle.
    assign w_grant_ok = w_grant_legal && !r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (!w_grant_legal) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

    for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_slot
        arb_client_slot #(
            .PEND_MAX   (PEND_MAX),
            .HOLD       (HOLD),
            .MIN_WAIT   (MIN_WAIT)
`ifdef ARB_CLIENT4_WDOG_EN
            ,
            .WDOG_LIMIT (WDOG_LIMIT)
`endif
        ) u_slot (
            .clk        (clock),
            .rst        (reset),
            .i_job      (job_i[i]),
            .i_grant    (grant_i[i]),
            .i_grant_ok (w_grant_ok),
            .o_request  (w_request[i]),
            .o_busy     (busy_o[i]),
            .o_done     (done_o[i]),
            .o_drop     (drop_o[i])
`ifdef ARB_CLIENT4_WDOG_EN
            ,
            .o_timeout  (timeout_o[i])
`endif
        );
    end

    assign request1 = w_request[C1];
    assign request2 = w_request[C2];
    assign request3 = w_request[C3];
    assign request4 = w_request[C4];

endmodule
`default_nettype wire

// File: tb/tb_arb_client4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arb_client4
//  Purpose  : Directed self-checking bench for arb_client4. Inputs change
//             1 time unit after a rising edge; outputs are sampled there too.
//             "cycle k" means the k-th clock period after the edge that
//             captured the stimulus job pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arb_client4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] job_i = 4'b0000;
    logic [3:0] grant_i = 4'b0000;
    logic       request1, request2, request3, request4;
    logic [3:0] busy_o, done_o, drop_o;
    logic       err_o;
`ifdef ARB_CLIENT4_WDOG_EN
    logic [3:0] timeout_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [3:0] w_req;
    assign w_req = {request1, request2, request3, request4};

    always #5 clock = ~clock;

    arb_client4 dut (
        .clock     (clock),
        .reset     (reset),
        .job_i     (job_i),
        .grant_i   (grant_i),
        .request1  (request1),
        .request2  (request2),
        .request3  (request3),
        .request4  (request4),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .drop_o    (drop_o),
        .err_o     (err_o)
`ifdef ARB_CLIENT4_WDOG_EN
        ,
        .timeout_o (timeout_o)
`endif
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        job_i   = 4'b0000;
        grant_i = 4'b0000;
        reset   = 1'b1;
        @(posedge clock);
        #1;
        reset   = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        check("rst_req",  w_req,  4'b0000);
        check("rst_busy", busy_o, 4'b0000);
        check("rst_done", done_o, 4'b0000);
        check("rst_drop", drop_o, 4'b0000);
        check("rst_err",  {3'b000, err_o}, 4'b0000);
        apply_reset();

        // ---------------- single job, client1 ----------------
        job_i = 4'b1000;
        tick();
        job_i = 4'b0000;                       // cycle 1
        check("t1_req_c1", w_req, 4'b1000);
        check("t1_busy_c1", busy_o, 4'b0000);
        tick();                                // cycle 2
        tick();                                // cycle 3
        grant_i = 4'b1000;
        #1;
        check("t1_early_grant_busy_c3", busy_o, 4'b0000);
        tick();                                // cycle 4
        check("t1_busy_c4", busy_o, 4'b0000);
        tick();                                // cycle 5: accept edge ends it
        check("t1_busy_c5", busy_o, 4'b0000);
        check("t1_req_c5", w_req, 4'b1000);
        for (int c = 6; c <= 10; c++) begin
            tick();
            check($sformatf("t1_busy_c%0d", c), busy_o, 4'b1000);
            check($sformatf("t1_done_c%0d", c), done_o, (c == 10) ? 4'b1000 : 4'b0000);
            check($sformatf("t1_req_c%0d", c), w_req, 4'b0000);
        end
        tick();                                // cycle 11
        grant_i = 4'b0000;
        check("t1_busy_c11", busy_o, 4'b0000);
        check("t1_done_c11", done_o, 4'b0000);
        tick();
        check("t1_req_idle", w_req, 4'b0000);

        // ---------------- pend saturation, client2 ----------------
        apply_reset();
        for (int k = 0; k < 9; k++) begin
            job_i = 4'b0100;
            #1;
            check($sformatf("t2_drop_job%0d", k), drop_o, (k >= 7) ? 4'b0100 : 4'b0000);
            tick();
        end
        job_i = 4'b0000;
        check("t2_req", w_req, 4'b0100);
        tick();
        check("t2_req_hold", w_req, 4'b0100);
        check("t2_drop_quiet", drop_o, 4'b0000);

        // ---------------- clients 1 and 3, grants in turn ----------------
        apply_reset();
        job_i = 4'b1010;
        tick();
        job_i   = 4'b0000;                     // cycle 1
        grant_i = 4'b1000;
        check("t3_req_c1", w_req, 4'b1010);
        repeat (4) tick();                     // cycle 5
        check("t3_busy_c5", busy_o, 4'b0000);
        tick();                                // cycle 6
        check("t3_busy_c6", busy_o, 4'b1000);
        check("t3_req_c6", w_req, 4'b0010);
        grant_i = 4'b0010;
        tick();                                // cycle 7
        check("t3_busy_c7", busy_o, 4'b1010);
        check("t3_req_c7", w_req, 4'b0000);
        grant_i = 4'b0000;
        tick();                                // cycle 8
        tick();                                // cycle 9
        check("t3_done_c9", done_o, 4'b0000);
        tick();                                // cycle 10
        check("t3_done_c10", done_o, 4'b1000);
        tick();                                // cycle 11
        check("t3_done_c11", done_o, 4'b0010);
        check("t3_busy_c11", busy_o, 4'b0010);
        tick();                                // cycle 12
        check("t3_busy_c12", busy_o, 4'b0000);
        check("t3_err", {3'b000, err_o}, 4'b0000);

        // ---------------- illegal grant ----------------
        apply_reset();
        job_i = 4'b1100;
        tick();
        job_i = 4'b0000;                       // cycle 1
        repeat (4) tick();                     // cycle 5
        grant_i = 4'b1100;
        #1;
        check("t4_err_same_cycle", {3'b000, err_o}, 4'b0000);
        tick();                                // cycle 6
        check("t4_err_set", {3'b000, err_o}, 4'b0001);
        check("t4_busy_c6", busy_o, 4'b0000);
        check("t4_req_c6", w_req, 4'b1100);
        grant_i = 4'b1000;
        tick();                                // cycle 7
        check("t4_busy_legal_after_err", busy_o, 4'b0000);
        check("t4_err_sticky", {3'b000, err_o}, 4'b0001);
        grant_i = 4'b0000;
        tick();
        check("t4_err_sticky2", {3'b000, err_o}, 4'b0001);
        apply_reset();
        check("t4_err_cleared", {3'b000, err_o}, 4'b0000);

        // ---------------- reset in the middle of USE, client4 ----------------
        apply_reset();
        job_i = 4'b0001;
        tick();
        job_i   = 4'b0000;                     // cycle 1
        grant_i = 4'b0001;
        repeat (5) tick();                     // cycle 6
        check("t5_busy_c6", busy_o, 4'b0001);
        tick();                                // cycle 7
        tick();                                // cycle 8: third USE cycle
        check("t5_busy_c8", busy_o, 4'b0001);
        check("t5_done_c8", done_o, 4'b0000);
        reset = 1'b1;
        #1;
        check("t5_async_busy", busy_o, 4'b0000);
        check("t5_async_done", done_o, 4'b0000);
        check("t5_async_req", w_req, 4'b0000);
        grant_i = 4'b0000;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        tick();
        check("t5_post_req", w_req, 4'b0000);
        check("t5_post_busy", busy_o, 4'b0000);
        check("t5_post_done", done_o, 4'b0000);

`ifdef ARB_CLIENT4_WDOG_EN
        // ---------------- REQ watchdog, client1 ----------------
        apply_reset();
        job_i = 4'b1000;
        tick();
        job_i = 4'b0000;                       // cycle 1
        repeat (63) tick();                    // cycle 64
        check("t6_timeout_c64", timeout_o, 4'b0000);
        tick();                                // cycle 65
        check("t6_timeout_c65", timeout_o, 4'b1000);
        check("t6_req_c65", w_req, 4'b1000);
        tick();
        check("t6_timeout_sticky", timeout_o, 4'b1000);
        check("t6_req_still", w_req, 4'b1000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
